// File: rtl/rv_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem handshake and IF/ID register.
// A response belonging to a squashed request is swallowed by the DRAIN state.
module rv_fetch_stage #(
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          if_flush,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] ifid_pc,
  output logic [31:0]   ifid_instr,
  output logic          ifid_valid
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [31:0]   hold_instr;
  logic          accept;
  logic          word_ready;
  logic          load_new;
  logic [31:0]   new_instr;

  assign imem_req   = (state == S_FETCH) && !rst;
  assign imem_addr  = pc;
  assign accept     = imem_req && imem_ready;
  assign word_ready = ((state == S_WAIT) && imem_rvalid) || (state == S_HOLD);
  assign load_new   = word_ready && !stall && !if_flush;
  assign new_instr  = (state == S_HOLD) ? hold_instr : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= S_FETCH;
      hold_instr <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      if (if_flush) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        if (load_new) begin
          ifid_instr <= new_instr;
          ifid_pc    <= pc;
          ifid_valid <= 1'b1;
        end else begin
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end
      end

      // A redirect decides whether an in-flight response still has to be swallowed.
      if (if_flush) begin
        pc <= branch_target;
        case (state)
          S_FETCH: state <= accept ? S_DRAIN : S_FETCH;
          S_WAIT:  state <= imem_rvalid ? S_FETCH : S_DRAIN;
          S_HOLD:  state <= S_FETCH;
          S_DRAIN: state <= imem_rvalid ? S_FETCH : S_DRAIN;
          default: state <= S_FETCH;
        endcase
      end else begin
        if (load_new) pc <= pc + AW'(4);
        case (state)
          S_FETCH: if (accept) state <= S_WAIT;
          S_WAIT: begin
            if (imem_rvalid) begin
              if (stall) begin
                hold_instr <= imem_rdata;
                state      <= S_HOLD;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          S_HOLD:  if (!stall) state <= S_FETCH;
          S_DRAIN: if (imem_rvalid) state <= S_FETCH;
          default: state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Scoreboard bench for rv_fetch_stage: a latency-configurable memory model feeds the DUT and
// every IF/ID load is popped against the queue of instructions the scenario expects to retire.
module tb_rv_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        if_flush;
  logic [31:0] branch_target;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;

  int          checks;
  int          fails;
  int          mem_lat;
  int          cnt;
  logic        pending;
  logic [31:0] pend_addr;
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];

  rv_fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .if_flush(if_flush), .branch_target(branch_target),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'h0050_0093 ^ ((a ^ 32'h4) << 7);
  endfunction

  // One clock: inputs sampled on the falling edge, memory model and load monitor updated after the rising edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    logic        stall_e;
    logic        rst_e;
    exp_t        e;
    @(negedge clk);
    acc     = imem_req && imem_ready;
    a       = imem_addr;
    stall_e = stall;
    rst_e   = rst;
    @(posedge clk);
    #1;
    if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      pending     = 1'b0;
    end
    if (acc) begin
      pending   = 1'b1;
      pend_addr = a;
      cnt       = mem_lat;
      acc_log.push_back(a);
    end else if (pending && cnt > 1) begin
      cnt--;
    end
    if (pending && cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_at(pend_addr);
    end
    if (!rst_e && !stall_e && ifid_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_load: got pc=%h instr=%h, expected no load", ifid_pc, ifid_instr);
      end else begin
        e = exp_q.pop_front();
        if (ifid_pc !== e.pc || ifid_instr !== e.instr) begin
          fails++;
          $display("[TB] FAIL load: got pc=%h instr=%h, expected pc=%h instr=%h",
                   ifid_pc, ifid_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; if_flush = 1'b0; imem_ready = 1'b1; branch_target = '0;
    tick();
    tick();
    pending = 1'b0; imem_rvalid = 1'b0; cnt = 0;
    exp_q.delete();
    acc_log.delete();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_accepts(input int n);
    for (int i = 0; i < 50 && acc_log.size() < n; i++) tick();
    checks++;
    if (acc_log.size() < n) begin
      fails++;
      $display("[TB] FAIL accept_timeout: got %0d accepts, expected %0d", acc_log.size(), n);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d loads outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; if_flush = 1'b0; imem_ready = 1'b1; branch_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; pending = 1'b0; cnt = 0; mem_lat = 1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_req: got %0b expected 0", imem_req);
    end
    checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_ifid: got v=%0b i=%h pc=%h expected v=0 i=%h pc=0", ifid_valid, ifid_instr, ifid_pc, NOP);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      fails++; $display("[TB] FAIL release_req: got %0b expected 1", imem_req);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] want;
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 3; k++) exp_q.push_back('{pc: 32'(k * 4), instr: instr_at(32'(k * 4))});
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (ifid_valid !== (i % 2 == 0)) begin
        fails++; $display("[TB] FAIL zw_valid_cycle%0d: got %0b expected %0b", i, ifid_valid, (i % 2 == 0));
      end
    end
    checks++;
    if (acc_log.size() != 3) begin
      fails++; $display("[TB] FAIL zw_accepts: got %0d expected 3", acc_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        want = 32'(k * 4);
        checks++;
        if (acc_log[k] !== want) begin
          fails++; $display("[TB] FAIL zw_addr%0d: got %h expected %h", k, acc_log[k], want);
        end
      end
    end
    drain();
  endtask

  task automatic test_flush_wait();
    do_reset();
    mem_lat = 2;
    exp_q.push_back('{pc: 32'h0, instr: instr_at(32'h0)});
    exp_q.push_back('{pc: 32'h4, instr: instr_at(32'h4)});
    exp_q.push_back('{pc: 32'h100, instr: instr_at(32'h100)});
    wait_accepts(3);
    checks++;
    if (acc_log.size() < 3 || acc_log[2] !== 32'h8) begin
      fails++; $display("[TB] FAIL fw_third_addr: got %h expected 00000008", acc_log.size() < 3 ? 32'hx : acc_log[2]);
    end
    if_flush = 1'b1; branch_target = 32'h100;
    tick();
    if_flush = 1'b0;
    checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
      fails++; $display("[TB] FAIL fw_bubble: got v=%0b i=%h expected v=0 i=%h", ifid_valid, ifid_instr, NOP);
    end
    tick();
    checks++;
    if (ifid_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL fw_stale_dropped: got valid=%0b instr=%h expected valid=0", ifid_valid, ifid_instr);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      fails++; $display("[TB] FAIL fw_redirect: got req=%0b addr=%h expected req=1 addr=00000100", imem_req, imem_addr);
    end
    wait_accepts(4);
    checks++;
    if (acc_log.size() < 4 || acc_log[3] !== 32'h100) begin
      fails++; $display("[TB] FAIL fw_next_accept: got %h expected 00000100", acc_log.size() < 4 ? 32'hx : acc_log[3]);
    end
    drain();
  endtask

  task automatic test_stall_hold();
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 3; k++) exp_q.push_back('{pc: 32'(k * 4), instr: instr_at(32'(k * 4))});
    for (int i = 0; i < 20 && exp_q.size() > 2; i++) tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== instr_at(32'h0)) begin
        fails++;
        $display("[TB] FAIL st_held%0d: got v=%0b pc=%h i=%h expected v=1 pc=0 i=%h", k, ifid_valid, ifid_pc, ifid_instr, instr_at(32'h0));
      end
    end
    checks++;
    if (imem_req !== 1'b0 || acc_log.size() != 2) begin
      fails++; $display("[TB] FAIL st_no_req: got req=%0b accepts=%0d expected req=0 accepts=2", imem_req, acc_log.size());
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h0050_0093 || ifid_pc !== 32'h4) begin
      fails++; $display("[TB] FAIL st_release: got v=%0b pc=%h i=%h expected v=1 pc=4 i=00500093", ifid_valid, ifid_pc, ifid_instr);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      fails++; $display("[TB] FAIL st_next_req: got req=%0b addr=%h expected req=1 addr=00000008", imem_req, imem_addr);
    end
    drain();
  endtask

  task automatic test_hold_flush();
    do_reset();
    mem_lat = 1;
    stall = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL hf_in_hold: got req=%0b v=%0b expected req=0 v=0", imem_req, ifid_valid);
    end
    if_flush = 1'b1; branch_target = 32'h40;
    tick();
    if_flush = 1'b0; stall = 1'b0;
    checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
      fails++; $display("[TB] FAIL hf_bubble: got v=%0b i=%h expected v=0 i=%h", ifid_valid, ifid_instr, NOP);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      fails++; $display("[TB] FAIL hf_redirect: got req=%0b addr=%h expected req=1 addr=00000040", imem_req, imem_addr);
    end
    exp_q.push_back('{pc: 32'h40, instr: instr_at(32'h40)});
    drain();
    checks++;
    if (acc_log.size() != 2 || acc_log[1] !== 32'h40) begin
      fails++; $display("[TB] FAIL hf_accepts: got n=%0d expected second accept 00000040", acc_log.size());
    end
  endtask

  task automatic test_ready_low_flush();
    do_reset();
    mem_lat = 1;
    imem_ready = 1'b0;
    tick();
    if_flush = 1'b1; branch_target = 32'h200;
    tick();
    if_flush = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      fails++; $display("[TB] FAIL rl_switch: got req=%0b addr=%h expected req=1 addr=00000200", imem_req, imem_addr);
    end
    tick();
    tick();
    checks++;
    if (acc_log.size() != 0 || ifid_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL rl_no_accept: got accepts=%0d v=%0b expected 0 and 0", acc_log.size(), ifid_valid);
    end
    imem_ready = 1'b1;
    exp_q.push_back('{pc: 32'h200, instr: instr_at(32'h200)});
    wait_accepts(1);
    checks++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'h200) begin
      fails++; $display("[TB] FAIL rl_first_accept: got %h expected 00000200", acc_log.size() < 1 ? 32'hx : acc_log[0]);
    end
    drain();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    mem_lat = 3;
    tick();
    rst = 1'b1; imem_ready = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++; $display("[TB] FAIL rw_req_in_reset: got %0b expected 0", imem_req);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
      fails++;
      $display("[TB] FAIL rw_after_reset: got req=%0b addr=%h v=%0b i=%h expected 1 0 0 %h", imem_req, imem_addr, ifid_valid, ifid_instr, NOP);
    end
    tick();
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP || imem_addr !== 32'h0) begin
      fails++; $display("[TB] FAIL rw_late_ignored: got v=%0b i=%h addr=%h expected v=0 i=%h addr=0", ifid_valid, ifid_instr, imem_addr, NOP);
    end
    imem_ready = 1'b1;
    exp_q.push_back('{pc: 32'h0, instr: instr_at(32'h0)});
    wait_accepts(1);
    drain();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_zero_wait();
    test_flush_wait();
    test_stall_hold();
    test_hold_flush();
    test_ready_low_flush();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rv_fetch_stage.md
Name: rv_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline: PC register, instruction-memory request/response handshake, and the IF/ID pipeline register.
- Feeds the ID-stage control decoder through ifid_instr.
- Consumes that decoder's if_flush (taken branch) and branch target, plus the hazard unit's stall.
- One outstanding memory request at a time; a stale response after a redirect is discarded.

Parameters:
- AW, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) written to IF/ID on flush/bubble.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  AW  fetch address (current PC)
- imem_ready  in  1  memory accepts request this cycle (accept = imem_req && imem_ready)
- imem_rvalid  in  1  response valid, at least 1 cycle after accept
- imem_rdata  in  32  fetched instruction
- stall  in  1  hazard unit: hold PC and IF/ID
- if_flush  in  1  taken branch: redirect and squash IF/ID
- branch_target  in  AW  redirect PC, sampled when if_flush=1
- ifid_pc  out  AW  PC of instruction in IF/ID
- ifid_instr  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (sync, overrides everything):
  - pc=RESET_PC, state=FETCH, hold register empty.
  - imem_req=0 in the reset cycle.
  - ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On accept -> WAIT. The request is not sticky: the memory samples imem_addr only in the accept cycle, so the address may change before acceptance.
  - WAIT: imem_req=0, awaiting imem_rvalid.
    - On rvalid with stall=0: ifid_instr=rdata, ifid_pc=pc, ifid_valid=1, pc<=pc+4 (mod 2^AW), -> FETCH.
    - On rvalid with stall=1: capture rdata in the hold register -> HOLD.
  - HOLD: imem_req=0. When stall=0: load IF/ID from the hold register (ifid_pc=pc, valid=1), pc<=pc+4, -> FETCH.
  - DRAIN: imem_req=0. The next imem_rvalid is discarded; -> FETCH (pc already redirected).
- imem_rvalid in FETCH, HOLD or DRAIN after its single discard is ignored.
- IF/ID update rules, in priority order:
  1. rst.
  2. if_flush.
  3. stall (hold all IF/ID fields).
  4. New instruction load.
  5. Otherwise load a bubble (NOP_INSTR, valid=0, ifid_pc unchanged).
- if_flush (priority over stall in the same cycle):
  - IF/ID <= bubble; pc <= branch_target.
  - FETCH without accept: stay FETCH; the next cycle requests branch_target.
  - FETCH with accept in the same cycle: the accepted address is stale -> DRAIN.
  - WAIT without rvalid: -> DRAIN.
  - WAIT with rvalid in the same cycle: drop the response -> FETCH.
  - HOLD: drop the held word -> FETCH.
- stall does not block issuing a request in FETCH; it only blocks the IF/ID load and the PC advance.
- Throughput: at most 1 instruction per 2 cycles (zero-wait memory gives accept at cycle N, rvalid at N+1, next request at N+2).
- No misalignment check; branch_target[1:0] is passed through unchanged.

Test Plan:
- Zero-wait memory (ready=1, rvalid 1 cycle after accept), after reset release -> imem_addr sequence 0x0,0x4,0x8; ifid_pc/ifid_instr follow with valid=1 every 2nd cycle and bubbles in between.
- Request at 0x8 accepted; if_flush=1 with branch_target=0x100 one cycle before rvalid -> IF/ID=NOP/valid=0, the 0x8 response is not loaded, next accepted address is 0x100.
- rvalid (rdata=0x00500093) arrives while stall=1 for 3 cycles -> IF/ID holds its previous contents; the cycle after stall drops, ifid_instr=0x00500093, valid=1, next request at pc+4.
- stall=1 and if_flush=1 in the same HOLD cycle with target 0x40 -> IF/ID=NOP/valid=0, held word dropped, next imem_addr=0x40.
- imem_ready=0 for 4 cycles in FETCH, with if_flush to 0x200 in cycle 2 -> imem_addr switches to 0x200, and the first accepted address is 0x200.
- rst asserted during WAIT, late rvalid 2 cycles after reset release -> rvalid ignored, imem_addr=RESET_PC, IF/ID stays NOP/valid=0 until the new response arrives.
